// File: rtl/serial_mantissa_adder_pkg.sv
// Shared constants for the mantissa datapath: FSM encoding and default mantissa width.
// Used by alignment, the serial adder and normalisation.
package serial_mantissa_adder_pkg;

    localparam int MANT_W = 24;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_mantissa_adder_fa.sv
// Single-bit full-adder cell.
// Latency: combinational.
// Backpressure: none.
module serial_mantissa_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_mantissa_adder.sv
// Bit-serial mantissa adder: {cout,sum} = a + b + cin, one bit per cycle through one full-adder cell.
// Latency: start accepted at edge T -> done during the cycle after edge T+WIDTH.
// Backpressure: start is ignored while busy; nothing is queued. A start in the DONE cycle is accepted.
module serial_mantissa_adder
    import serial_mantissa_adder_pkg::*;
#(
    parameter int WIDTH = MANT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sh, b_sh, ps_sh, ps_next;
    logic             carry;
    logic [CW-1:0]    count;
    logic             fa_s, fa_co;
    logic             accept, last;

    serial_mantissa_adder_fa u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign accept = start && (state_q != S_RUN);
    assign last   = (state_q == S_RUN) && (count == LAST);
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);

    // LSB-first: each new sum bit enters at the top, so after WIDTH shifts the word is aligned.
    always_comb begin
        ps_next = ps_sh >> 1;
        ps_next[WIDTH-1] = fa_s;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            ps_sh <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            ps_sh <= '0;
            carry <= cin;
            count <= '0;
        end else if (state_q == S_RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            ps_sh <= ps_next;
            carry <= fa_co;
            count <= count + CW'(1);
            if (last) begin
                sum  <= ps_next;
                cout <= fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_mantissa_adder.sv
// Self-checking bench: directed cases plus randomised operands against a plain a+b+cin model.
module tb_serial_mantissa_adder;

    localparam int W = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic          cin = 1'b0;
    logic          busy, done, cout;
    logic [W-1:0]  sum;

    logic          start1 = 1'b0;
    logic [0:0]    a1 = '0, b1 = '0;
    logic          cin1 = 1'b0;
    logic          busy1, done1, cout1;
    logic [0:0]    sum1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_mantissa_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_mantissa_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All stimulus happens 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        a = x; b = y; cin = ci; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles from the acceptance edge until done is seen, with a timeout.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        if (!done) check("timeout_done", 64'(done), 64'(1));
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic ci);
        logic [W:0] model;
        model = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        check({tag, "_sum"}, 64'(sum), 64'(model[W-1:0]));
        check({tag, "_cout"}, 64'(cout), 64'(model[W]));
    endtask

    initial begin
        int lat, bcnt, seen;
        logic [W-1:0] x, y;
        logic ci;

        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        check("rst_busy1", 64'(busy1), 64'(0));
        rst = 1'b0;
        tick();

        // 1 + 1: latency, busy length, single done pulse
        issue(24'h000001, 24'h000001, 1'b0);
        wait_done(lat, bcnt);
        check("lat_basic", 64'(lat), 64'(W));
        check("busy_len", 64'(bcnt), 64'(W));
        check("basic_sum", 64'(sum), 64'(24'h000002));
        check("basic_cout", 64'(cout), 64'(0));
        tick();
        check("done_pulse", 64'(done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));

        issue(24'hFFFFFF, 24'h000000, 1'b1);
        wait_done(lat, bcnt);
        check("ovf_sum", 64'(sum), 64'(0));
        check("ovf_cout", 64'(cout), 64'(1));
        tick();

        issue(24'h800000, 24'h800000, 1'b0);
        wait_done(lat, bcnt);
        check("msb_sum", 64'(sum), 64'(0));
        check("msb_cout", 64'(cout), 64'(1));
        tick();

        // start held and operands scrambled during RUN must be ignored
        a = 24'h00000B; b = 24'h000016; cin = 1'b0; start = 1'b1;
        tick();
        lat = 0;
        while (!done && lat < 200) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            tick();
            lat++;
        end
        start = 1'b0;
        check("hold_lat", 64'(lat), 64'(W));
        check("hold_sum", 64'(sum), 64'(24'h000021));
        tick();
        check("hold_idle", 64'(busy), 64'(0));

        // reset in the middle of a run
        issue(24'h0F0F0F, 24'h010101, 1'b1);
        repeat (10) tick();
        check("mid_busy_pre", 64'(busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", 64'(busy), 64'(0));
        check("mrst_done", 64'(done), 64'(0));
        check("mrst_sum", 64'(sum), 64'(0));
        check("mrst_cout", 64'(cout), 64'(0));
        seen = 0;
        repeat (30) begin
            tick();
            if (done) seen++;
        end
        check("mrst_no_done", 64'(seen), 64'(0));

        // back-to-back: start in the DONE cycle
        issue(24'h000005, 24'h000007, 1'b1);
        wait_done(lat, bcnt);
        check("b2b_first_sum", 64'(sum), 64'(24'h00000D));
        a = 24'h123456; b = 24'h654321; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'(1));
        check("b2b_hold_sum", 64'(sum), 64'(24'h00000D));
        wait_done(lat, bcnt);
        check("b2b_gap", 64'(lat + 1), 64'(W + 1));
        check("b2b_sum", 64'(sum), 64'(24'h777777));
        check("b2b_cout", 64'(cout), 64'(0));
        tick();

        // WIDTH=1 instance
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1_busy", 64'(busy1), 64'(1));
        tick();
        check("w1_done", 64'(done1), 64'(1));
        check("w1_sum", 64'(sum1), 64'(1));
        check("w1_cout", 64'(cout1), 64'(1));
        tick();
        check("w1_pulse", 64'(done1), 64'(0));

        // randomised operations
        for (int i = 0; i < 1000; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            ci = 1'($urandom);
            if (i % 8 == 0) x = '1;
            issue(x, y, ci);
            wait_done(lat, bcnt);
            if (i < 4) check("rnd_lat", 64'(lat), 64'(W));
            expect_result("rnd", x, y, ci);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/serial_mantissa_adder.md
Name: serial_mantissa_adder

Overview:
- Bit-serial mantissa adder for the floating-point add datapath.
- Sits after exponent alignment and before normalisation.
- Consumes two aligned WIDTH-bit mantissas plus a carry-in, adds one bit per cycle through a single full-adder cell, and returns a registered sum and carry-out with a done pulse.
- Area-saving alternative to the ripple-carry mantissa adder; same arithmetic result.

Parameters:
- WIDTH, 24, mantissa width in bits including the hidden bit; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request to begin an addition; sampled only when accepted (see Behaviour)
- a  input  WIDTH  aligned mantissa A; captured on start acceptance
- b  input  WIDTH  aligned mantissa B; captured on start acceptance
- cin  input  1  carry-in; captured on start acceptance
- busy  output  1  high while an addition is in progress (state RUN)
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  WIDTH  registered result a+b+cin, modulo 2^WIDTH
- cout  output  1  registered carry-out of bit WIDTH-1

Behaviour:
- Reset values: while rst is high at a clock edge, all of the following are forced: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers=0, carry flop=0, bit counter=0.
- Reset takes effect on a clock edge only, and from any state including mid-RUN. An interrupted addition is discarded and no done pulse is produced.
- State machine (three states):
  - IDLE: busy=0. start=1 → load A-shreg=a, B-shreg=b, carry=cin, count=0, partial-sum shreg=0; go to RUN.
  - RUN: busy=1. Each cycle the full-adder cell takes A-shreg[0], B-shreg[0] and carry.
    - Its sum bit shifts into the MSB of the partial-sum shreg (right shift).
    - A-shreg and B-shreg shift right by one, with 0 filled in.
    - carry <= cell Cout; count <= count+1.
    - When count == WIDTH-1 this cycle: go to DONE, and on the same edge set sum <= final partial sum and cout <= cell Cout.
  - DONE: done=1, busy=0, for exactly one cycle. start=1 → accept a new operation exactly as from IDLE and go to RUN (back-to-back allowed). Otherwise go to IDLE.
- start while in RUN is ignored. Operands are not captured and nothing is queued.
- Latency: start accepted at edge T → done high during the cycle after edge T+WIDTH. Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- sum/cout change only on the RUN→DONE edge or on reset. They hold their value through IDLE and through a subsequent RUN until that run completes.
- Arithmetic: unsigned; {cout,sum} == a + b + cin exactly.
- Bit counter width is $clog2(WIDTH+1) and must not wrap before WIDTH-1 is reached.
- WIDTH=1: RUN lasts one cycle, then DONE.
- a, b and cin are don't-care except on the acceptance edge.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default mantissa width constant MANT_W=24, so the alignment and normalisation stages share it.
- One sub-module: the team's existing single-bit full-adder cell, instantiated once for the serial bit slice.
- The FSM, shift registers, counter and output registers stay in this module.

Test Plan:
- WIDTH=24, a=24'h000001, b=24'h000001, cin=0, start 1 cycle → after 24 RUN cycles, done pulses once; sum=24'h000002, cout=0; busy high exactly 24 cycles.
- a=24'hFFFFFF, b=24'h000000, cin=1 → sum=24'h000000, cout=1; then a=24'h800000, b=24'h800000, cin=0 → sum=0, cout=1.
- Start accepted, then start held high and a/b changed during RUN → result still reflects first operands; no second run begins until DONE.
- rst asserted at RUN cycle 10 → next cycle busy=0, done=0, sum=0, cout=0, state IDLE; no done pulse follows.
- start asserted in the DONE cycle with a=24'h123456, b=24'h654321, cin=0 → immediate RUN; second done 25 cycles after the first; sum=24'h777777, cout=0.
- WIDTH=1 build: a=1, b=1, cin=1 → done 2 cycles after start; sum=1, cout=1. Randomised 1000 ops at WIDTH=24 checked against a+b+cin.
